// File: rtl/beam_pkg.sv
// Shared definitions for the beam event generator.
// Holds the strobe FSM state encoding and the width of the per-output
// pending-event counter.
package beam_pkg;

    // Strobe shaping FSM: idle, strobe held low, then enforced high gap
    typedef enum logic [1:0] {
        StIdle,
        StLow,
        StGap
    } strobe_state_e;

    localparam int unsigned PEND_W = 2;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

endpackage

// File: rtl/beam_channel.sv
// One photo-beam conditioning channel.
// Synchronises the raw beam, debounces it, flags the clear->blocked transition
// as a one-cycle event and reports a beam blocked for too long.
// Ports:
//   clk       system clock, rising edge
//   Resetn    asynchronous active-low reset
//   beam_raw  raw asynchronous beam (1 = clear, 0 = blocked)
//   evt       one-cycle pulse when the debounced level falls to 0
//   stuck     debounced level held at 0 for STUCK_CYCLES cycles or more
module beam_channel #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned STUCK_CYCLES    = 1000
) (
    input  logic clk,
    input  logic Resetn,
    input  logic beam_raw,
    output logic evt,
    output logic stuck
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned ST_W = $clog2(STUCK_CYCLES) + 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_MAX  = ST_W'(STUCK_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   beam_sync;
    logic                   deb_q, deb_d;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic                   evt_q, evt_d;
    logic [ST_W-1:0]        st_cnt_q, st_cnt_d;

    assign beam_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        deb_d    = deb_q;
        db_cnt_d = '0;
        evt_d    = 1'b0;
        // Count consecutive cycles the synced level disagrees; any agreement
        // (a bounce back) leaves the count at zero.
        if (beam_sync != deb_q) begin
            if (db_cnt_q == DB_LAST) begin
                deb_d = beam_sync;
                evt_d = ~beam_sync;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        st_cnt_d = st_cnt_q;
        if (deb_q) begin
            st_cnt_d = '0;
        end else if (st_cnt_q != ST_MAX) begin
            st_cnt_d = st_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            sync_q   <= '1;
            deb_q    <= 1'b1;
            db_cnt_q <= '0;
            evt_q    <= 1'b0;
            st_cnt_q <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], beam_raw};
            deb_q    <= deb_d;
            db_cnt_q <= db_cnt_d;
            evt_q    <= evt_d;
            st_cnt_q <= st_cnt_d;
        end
    end

    assign evt   = evt_q;
    // Gated by the live level so the flag drops the cycle the beam clears
    assign stuck = (st_cnt_q == ST_MAX) & ~deb_q;

endmodule

// File: rtl/beam_event_gen.sv
// Beam event generator: turns the back (entry) and front (exit) photo beams
// into clean active-low count strobes for the people counter.
// Ports:
//   clk           system clock, rising edge
//   Resetn        asynchronous active-low reset
//   back_beam_i   raw back beam, async (1 = clear, 0 = blocked)
//   front_beam_i  raw front beam, async (1 = clear, 0 = blocked)
//   up_count      active-low entry strobe, idle 1
//   down_count    active-low exit strobe, idle 1
//   both_evt      1-cycle pulse: simultaneous entry/exit cancelled
//   evt_drop      1-cycle pulse: event lost, pending buffer full
//   back_stuck    back beam blocked for STUCK_CYCLES or more
//   front_stuck   front beam blocked for STUCK_CYCLES or more
module beam_event_gen
    import beam_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PULSE_CYCLES    = 2,
    parameter int unsigned STUCK_CYCLES    = 1000
) (
    input  logic clk,
    input  logic Resetn,
    input  logic back_beam_i,
    input  logic front_beam_i,
    output logic up_count,
    output logic down_count,
    output logic both_evt,
    output logic evt_drop,
    output logic back_stuck,
    output logic front_stuck
);

    localparam int unsigned PL_W = $clog2(PULSE_CYCLES) + 1;
    localparam logic [PL_W-1:0] PL_LAST = PL_W'(PULSE_CYCLES - 1);

    logic       back_evt, front_evt;
    logic [1:0] inc;
    logic [1:0] strobe;
    logic [1:0] drop_v;
    logic       both_q, drop_q;

    beam_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_back (
        .clk      (clk),
        .Resetn   (Resetn),
        .beam_raw (back_beam_i),
        .evt      (back_evt),
        .stuck    (back_stuck)
    );

    beam_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_front (
        .clk      (clk),
        .Resetn   (Resetn),
        .beam_raw (front_beam_i),
        .evt      (front_evt),
        .stuck    (front_stuck)
    );

    // Simultaneous entry and exit net to zero: neither is queued
    assign inc[0] = back_evt & ~front_evt;
    assign inc[1] = front_evt & ~back_evt;

    // Output 0 drives up_count, output 1 drives down_count
    for (genvar g = 0; g < 2; g++) begin : g_out
        strobe_state_e     state_q, state_d;
        logic [PEND_W-1:0] pend_q, pend_d;
        logic [PL_W-1:0]   pcnt_q, pcnt_d;
        logic              strobe_q;
        logic              dec;
        logic              drop;

        always_comb begin
            state_d = state_q;
            pcnt_d  = pcnt_q;
            dec     = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pend_q != '0) begin
                        state_d = StLow;
                        pcnt_d  = '0;
                        dec     = 1'b1;
                    end
                end
                StLow: begin
                    if (pcnt_q == PL_LAST) begin
                        state_d = StGap;
                        pcnt_d  = '0;
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                end
                StGap: begin
                    if (pcnt_q == PL_LAST) begin
                        state_d = StIdle;
                        pcnt_d  = '0;
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase

            // A new event and a launch in the same cycle cancel; only a
            // full buffer with no launch loses the event.
            pend_d = pend_q;
            drop   = 1'b0;
            if (inc[g] && !dec) begin
                if (pend_q == PEND_MAX) begin
                    drop = 1'b1;
                end else begin
                    pend_d = pend_q + 1'b1;
                end
            end else if (!inc[g] && dec) begin
                pend_d = pend_q - 1'b1;
            end
        end

        always_ff @(posedge clk or negedge Resetn) begin
            if (!Resetn) begin
                state_q  <= StIdle;
                pend_q   <= '0;
                pcnt_q   <= '0;
                strobe_q <= 1'b1;
            end else begin
                state_q  <= state_d;
                pend_q   <= pend_d;
                pcnt_q   <= pcnt_d;
                // Registered so the strobe is glitch-free toward the counter
                strobe_q <= (state_d != StLow);
            end
        end

        assign strobe[g] = strobe_q;
        assign drop_v[g] = drop;
    end

    always_ff @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            both_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            both_q <= back_evt & front_evt;
            drop_q <= |drop_v;
        end
    end

    assign up_count   = strobe[0];
    assign down_count = strobe[1];
    assign both_evt   = both_q;
    assign evt_drop   = drop_q;

endmodule

// File: tb/tb_beam_event_gen.sv
// Self-checking bench for beam_event_gen.
// Two instances share the beam inputs: instance a uses the default timing,
// instance b uses long pulses and a short stuck limit so that buffer overflow
// and stuck flagging are reachable within a short run.
// The reference model works from the beam's sampled history: a debounced fall
// is an event, each accepted event gets a pulse start time
// max(accept+1, previous start + 2*PULSE+1), and the pending depth is the
// number of start times not yet reached.
module tb_beam_event_gen;

    localparam int S   = 2;
    localparam int D   = 4;
    localparam int W   = S + D;
    localparam int P_A = 2;
    localparam int P_B = 16;
    localparam int K_A = 1000;
    localparam int K_B = 40;

    logic       clk = 1'b0;
    logic       Resetn = 1'b0;
    logic       back_beam = 1'b1;
    logic       front_beam = 1'b1;
    logic [1:0] up, down, both, drop, bstk, fstk;

    always #5 clk = ~clk;

    beam_event_gen #(
        .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P_A), .STUCK_CYCLES(K_A)
    ) u_dut_a (
        .clk(clk), .Resetn(Resetn), .back_beam_i(back_beam), .front_beam_i(front_beam),
        .up_count(up[0]), .down_count(down[0]), .both_evt(both[0]), .evt_drop(drop[0]),
        .back_stuck(bstk[0]), .front_stuck(fstk[0])
    );

    beam_event_gen #(
        .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P_B), .STUCK_CYCLES(K_B)
    ) u_dut_b (
        .clk(clk), .Resetn(Resetn), .back_beam_i(back_beam), .front_beam_i(front_beam),
        .up_count(up[1]), .down_count(down[1]), .both_evt(both[1]), .evt_drop(drop[1]),
        .back_stuck(bstk[1]), .front_stuck(fstk[1])
    );

    int checks = 0;
    int failures = 0;
    int ec = 0;
    int pcyc [2] = '{P_A, P_B};
    int kcyc [2] = '{K_A, K_B};

    // Reference model state
    logic [W-1:0] hist [2];
    logic deb_m [2];
    logic pev [2];
    int   fall_e [2];
    int   st [4][4];
    logic exp_both;
    logic exp_drop [2];

    // Observation counters, indexed inst*2+out
    int   n_pulse [4];
    int   first_lo [4];
    logic prev_lo [4];
    int   n_both [2];
    int   n_drop [2];
    int   first_fstk;
    int   fstk_clear;

    task automatic chk(input string tag, input logic got, input logic want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s @edge %0d: observed %b expected %b", tag, ec, got, want);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int want);
        checks++;
        assert (got == want) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            hist[c]     = '1;
            deb_m[c]    = 1'b1;
            pev[c]      = 1'b0;
            fall_e[c]   = 0;
            exp_drop[c] = 1'b0;
        end
        for (int j = 0; j < 4; j++)
            for (int k = 0; k < 4; k++) st[j][k] = -1000;
        exp_both = 1'b0;
    endfunction

    // Returns 1 when the event is lost to a full buffer
    function automatic logic accept(input int j, input int p);
        int   pend = 0;
        logic dec = 1'b0;
        int   s;
        for (int k = 0; k < 4; k++) begin
            if (st[j][k] >= ec) pend++;
            if (st[j][k] == ec) dec = 1'b1;
        end
        if (pend == 3 && !dec) return 1'b1;
        s = st[j][0] + 2 * p + 1;
        if (ec + 1 > s) s = ec + 1;
        for (int k = 3; k > 0; k--) st[j][k] = st[j][k-1];
        st[j][0] = s;
        return 1'b0;
    endfunction

    function automatic logic lo_exp(input int j, input int p);
        for (int k = 0; k < 4; k++)
            if (st[j][k] <= ec && ec <= st[j][k] + p - 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_step();
        exp_both = pev[0] && pev[1];
        exp_drop[0] = 1'b0;
        exp_drop[1] = 1'b0;
        if (!exp_both) begin
            for (int o = 0; o < 2; o++)
                if (pev[o])
                    for (int i = 0; i < 2; i++)
                        if (accept(i * 2 + o, pcyc[i])) exp_drop[i] = 1'b1;
        end
        for (int c = 0; c < 2; c++) begin
            hist[c] = {hist[c][W-2:0], (c == 0) ? back_beam : front_beam};
            pev[c]  = 1'b0;
            if (deb_m[c] && hist[c][W-1:S] == {D{1'b0}}) begin
                deb_m[c]  = 1'b0;
                pev[c]    = 1'b1;
                fall_e[c] = ec;
            end else if (!deb_m[c] && hist[c][W-1:S] == {D{1'b1}}) begin
                deb_m[c] = 1'b1;
            end
        end
    endfunction

    task automatic check_all();
        string nm [2] = '{"a", "b"};
        for (int i = 0; i < 2; i++) begin
            chk({"up_", nm[i]}, up[i], !lo_exp(i * 2, pcyc[i]));
            chk({"down_", nm[i]}, down[i], !lo_exp(i * 2 + 1, pcyc[i]));
            chk({"both_", nm[i]}, both[i], exp_both);
            chk({"drop_", nm[i]}, drop[i], exp_drop[i]);
            chk({"bstk_", nm[i]}, bstk[i], !deb_m[0] && (ec - fall_e[0] >= kcyc[i]));
            chk({"fstk_", nm[i]}, fstk[i], !deb_m[1] && (ec - fall_e[1] >= kcyc[i]));
        end
    endtask

    task automatic observe();
        logic v;
        for (int j = 0; j < 4; j++) begin
            v = (j % 2 == 0) ? up[j/2] : down[j/2];
            if (v === 1'b0 && !prev_lo[j]) begin
                n_pulse[j]++;
                if (first_lo[j] < 0) first_lo[j] = ec;
            end
            prev_lo[j] = (v === 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            if (both[i] === 1'b1) n_both[i]++;
            if (drop[i] === 1'b1) n_drop[i]++;
        end
        if (fstk[0] === 1'b1 && first_fstk < 0) first_fstk = ec;
        if (fstk[0] === 1'b0 && first_fstk >= 0 && fstk_clear < 0) fstk_clear = ec;
    endtask

    task automatic clr_obs();
        for (int j = 0; j < 4; j++) begin
            n_pulse[j]  = 0;
            first_lo[j] = -1;
        end
        for (int i = 0; i < 2; i++) begin
            n_both[i] = 0;
            n_drop[i] = 0;
        end
        first_fstk = -1;
        fstk_clear = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        ec++;
        if (!Resetn) model_reset();
        else model_step();
        #1;
        check_all();
        observe();
    endtask

    task automatic async_reset();
        #2;
        Resetn = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (3) tick();
        Resetn = 1'b1;
    endtask

    initial begin
        int k;
        int r;
        for (int j = 0; j < 4; j++) prev_lo[j] = 1'b0;
        model_reset();
        clr_obs();
        repeat (3) tick();
        Resetn = 1'b1;

        // Idle beams: no activity at all
        clr_obs();
        repeat (50) tick();
        chk_int("idle_pulses", n_pulse[0] + n_pulse[1] + n_pulse[2] + n_pulse[3], 0);
        chk_int("idle_flags", n_both[0] + n_both[1] + n_drop[0] + n_drop[1], 0);

        // Single entry: latency and pulse count
        clr_obs();
        back_beam = 1'b0;
        k = ec + 1;
        repeat (30) tick();
        chk_int("lat_up_a", first_lo[0], k + S + D + 1);
        chk_int("lat_up_b", first_lo[2], k + S + D + 1);
        chk_int("one_up_a", n_pulse[0], 1);
        chk_int("no_down_a", n_pulse[1], 0);
        back_beam = 1'b1;
        repeat (80) tick();

        // Bouncing exit: one pulse timed from the final fall
        clr_obs();
        front_beam = 1'b0;
        tick();
        front_beam = 1'b1;
        tick();
        front_beam = 1'b0;
        k = ec + 1;
        repeat (30) tick();
        chk_int("bounce_lat_a", first_lo[1], k + S + D + 1);
        chk_int("bounce_one_a", n_pulse[1], 1);
        front_beam = 1'b1;
        repeat (80) tick();

        // Simultaneous entry and exit cancel
        clr_obs();
        back_beam  = 1'b0;
        front_beam = 1'b0;
        repeat (20) tick();
        back_beam  = 1'b1;
        front_beam = 1'b1;
        repeat (20) tick();
        chk_int("both_a", n_both[0], 1);
        chk_int("both_b", n_both[1], 1);
        chk_int("both_no_pulse", n_pulse[0] + n_pulse[1] + n_pulse[2] + n_pulse[3], 0);
        repeat (60) tick();

        // Five entries 8 cycles apart: long pulses on b overflow the buffer
        clr_obs();
        repeat (5) begin
            back_beam = 1'b0;
            repeat (4) tick();
            back_beam = 1'b1;
            repeat (4) tick();
        end
        repeat (200) tick();
        chk_int("burst_up_a", n_pulse[0], 5);
        chk_int("burst_drop_a", n_drop[0], 0);
        chk_int("burst_up_b", n_pulse[2], 4);
        chk_int("burst_drop_b", n_drop[1], 1);

        // Front beam held blocked past the stuck limit, then released
        clr_obs();
        front_beam = 1'b0;
        k = ec + 1;
        repeat (1010) tick();
        chk_int("fstk_set_a", first_fstk, k + S + D - 1 + K_A);
        front_beam = 1'b1;
        r = ec + 1;
        repeat (20) tick();
        chk_int("fstk_clr_a", fstk_clear, r + S + D - 1);
        repeat (80) tick();

        // Reset while strobing with an event still pending
        repeat (2) begin
            back_beam = 1'b0;
            repeat (4) tick();
            back_beam = 1'b1;
            repeat (4) tick();
        end
        chk_int("pre_rst_low_b", int'(up[1]), 0);
        async_reset();
        clr_obs();
        repeat (60) tick();
        chk_int("post_rst_pulses", n_pulse[0] + n_pulse[1] + n_pulse[2] + n_pulse[3], 0);

        // Random beam activity against the model
        repeat (150) begin
            back_beam  = $urandom_range(0, 1) != 0;
            front_beam = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 9) == 0) repeat (60) tick();
            else repeat ($urandom_range(1, 12)) tick();
        end
        back_beam  = 1'b1;
        front_beam = 1'b1;
        repeat (150) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
